// File: rtl/clock_tick_ctrl.sv
// Clock-chain control: seconds prescaler plus debounced mode/inc buttons feeding a RUN/SET_HR/SET_MIN FSM.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat of increment pulses while btn_inc is held in a set state.
//
// state   | meaning
// RUN     | prescaler counting, sec_tick every DIV cycles, inc presses ignored
// SET_HR  | prescaler held at 0, inc press -> hr_inc pulse
// SET_MIN | prescaler held at 0, inc press -> min_inc pulse
module clock_tick_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic       min_inc,
  output logic       hr_inc,
  output logic [1:0] mode,
  output logic       running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES) + 1;

  if (DIV < 2) begin : g_div_chk
    $error("clock_tick_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_deb_chk
    $error("clock_tick_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_rep_chk
    $error("clock_tick_ctrl: REPEAT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [1:0]      sync1, sync2, db, db_q;
  logic [DW-1:0]   db_cnt [2];
  logic            mode_press, inc_press, inc_evt;

  // bit 0 = mode button, bit 1 = inc button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign mode_press = db[0] & ~db_q[0];
  assign inc_press  = db[1] & ~db_q[1];

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_arm;
  logic          rep_fire;

  assign rep_fire = rep_arm & db[1] & (rep_cnt == RW'(REPEAT_CYCLES - 1));
  assign inc_evt  = inc_press | rep_fire;

  // Armed only by a press accepted in a set state; any mode change or release disarms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_arm <= 1'b0;
      rep_cnt <= '0;
    end else if (!db[1] || mode_press || state == RUN) begin
      rep_arm <= 1'b0;
      rep_cnt <= '0;
    end else if (inc_press) begin
      rep_arm <= 1'b1;
      rep_cnt <= '0;
    end else if (rep_arm) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end
`else
  assign inc_evt = inc_press;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      running  <= 1'b1;
      presc    <= '0;
      sec_tick <= 1'b0;
      hr_inc   <= 1'b0;
      min_inc  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      hr_inc   <= 1'b0;
      min_inc  <= 1'b0;
      case (state)
        RUN: begin
          // a mode press in the terminal cycle still lets this tick out
          sec_tick <= (presc == PW'(DIV - 1));
          presc    <= (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;
          if (mode_press) begin
            state   <= SET_HR;
            running <= 1'b0;
          end
        end
        SET_HR: begin
          presc <= '0;
          if (mode_press) state <= SET_MIN;
          else if (inc_evt) hr_inc <= 1'b1;
        end
        SET_MIN: begin
          presc <= '0;
          if (mode_press) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (inc_evt) begin
            min_inc <= 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          running <= 1'b1;
          presc   <= '0;
        end
      endcase
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_tick_ctrl.sv
// Bench for clock_tick_ctrl: directed segment table, reset corner case, then random buttons against a window-rule model.
module tb_clock_tick_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 4;
  localparam int REP = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc;
  logic       sec_tick, min_inc, hr_inc, running;
  logic [1:0] mode;

  always #5 clk = ~clk;

  clock_tick_ctrl #(
    .CLK_HZ(20), .TICK_HZ(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_tick(sec_tick), .min_inc(min_inc), .hr_inc(hr_inc),
    .mode(mode), .running(running)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int edge_cnt, run_start, m_mode;
  bit m_tick, m_hr, m_min;
  bit h_m[$], h_i[$];
  bit db_m, db_i, ev_m, ev_i;
`ifdef AUTO_REPEAT_EN
  bit arm;
  int last_pulse;
`endif
  int n_tick, n_hr, n_min;

  typedef struct {
    bit bm;
    bit bi;
    int n;
    int mode_end;
    int ticks;
    int hrs;
    int mins;
    int tick_end;
  } seg_t;

  seg_t tbl[25];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_cnt, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_tick = 0; m_hr = 0; m_min = 0;
    db_m = 0; db_i = 0; ev_m = 0; ev_i = 0;
    h_m = {}; h_i = {};
    for (int k = 0; k <= DEB; k++) begin
      h_m.push_back(1'b0);
      h_i.push_back(1'b0);
    end
    run_start = edge_cnt;
`ifdef AUTO_REPEAT_EN
    arm = 0; last_pulse = 0;
`endif
  endfunction

  // Level flips once the last DEB synchronized samples (raw delayed two edges) all disagree with it.
  function automatic bit flips(bit h[$], bit db);
    for (int k = 1; k <= DEB; k++) if (h[k] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(bit rm, bit ri);
    int e, pm;
    bit inc_evt;
    edge_cnt++;
    e = edge_cnt;
    pm = m_mode;
    m_tick = (pm == 0) && (((e - run_start) % DIV) == 0);
    m_hr = 0; m_min = 0;
    inc_evt = ev_i;
`ifdef AUTO_REPEAT_EN
    if (arm && db_i && pm != 0 && (e - last_pulse) == REP) inc_evt = 1;
`endif
    if (ev_m) begin
      m_mode = (pm + 1) % 3;
      if (m_mode == 0) run_start = e;
    end else if (inc_evt && pm == 1) m_hr = 1;
    else if (inc_evt && pm == 2) m_min = 1;
`ifdef AUTO_REPEAT_EN
    if (ev_m || !db_i || pm == 0) arm = 0;
    else if (ev_i) begin arm = 1; last_pulse = e; end
    else if (inc_evt) last_pulse = e;
`endif
    if (flips(h_m, db_m)) begin db_m = !db_m; ev_m = db_m; end else ev_m = 0;
    if (flips(h_i, db_i)) begin db_i = !db_i; ev_i = db_i; end else ev_i = 0;
    h_m.push_front(rm); void'(h_m.pop_back());
    h_i.push_front(ri); void'(h_i.pop_back());
  endfunction

  function automatic void check_model();
    chk("sec_tick", int'(sec_tick), int'(m_tick));
    chk("hr_inc", int'(hr_inc), int'(m_hr));
    chk("min_inc", int'(min_inc), int'(m_min));
    chk("mode", int'(mode), m_mode);
    chk("running", int'(running), (m_mode == 0) ? 1 : 0);
  endfunction

  task automatic tick_cycle();
    @(posedge clk);
    if (!reset) model_step(btn_mode, btn_inc);
    #1;
    check_model();
    n_tick += int'(sec_tick);
    n_hr   += int'(hr_inc);
    n_min  += int'(min_inc);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 35, 0, 3, 0, 0, 0};
    tbl[1]  = '{1, 0,  3, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0,  7, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0,  8, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 10, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1,  6, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 10, 1, 0, 1, 0, 0};
    tbl[7]  = '{1, 0,  6, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 10, 2, 0, 0, 0, 0};
    tbl[9]  = '{0, 1,  6, 2, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 10, 2, 0, 0, 1, 0};
    tbl[11] = '{1, 0,  6, 2, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 25, 0, 2, 0, 0, 0};
    tbl[13] = '{1, 0,  6, 0, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 10, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 1,  6, 1, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 10, 2, 0, 0, 0, 0};
    tbl[17] = '{1, 0,  6, 2, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 10, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 10, 0, 1, 0, 0, 0};
    tbl[20] = '{0, 0,  5, 0, 1, 0, 0, 0};
    tbl[21] = '{1, 0,  6, 0, 1, 0, 0, 1};
    tbl[22] = '{0, 0, 15, 1, 0, 0, 0, 0};
    tbl[23] = '{1, 0,  6, 1, 0, 0, 0, 0};
    tbl[24] = '{0, 0, 10, 2, 0, 0, 0, 0};

    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    edge_cnt = 0; n_tick = 0; n_hr = 0; n_min = 0;
    model_reset();
    #1;
    chk("reset_mode", int'(mode), 0);
    chk("reset_running", int'(running), 1);
    repeat (3) tick_cycle();
    reset = 1'b0;

    for (int s = 0; s < 25; s++) begin
      btn_mode = tbl[s].bm;
      btn_inc  = tbl[s].bi;
      n_tick = 0; n_hr = 0; n_min = 0;
      for (int c = 0; c < tbl[s].n; c++) tick_cycle();
      chk($sformatf("seg%0d_mode", s), int'(mode), tbl[s].mode_end);
      chk($sformatf("seg%0d_ticks", s), n_tick, tbl[s].ticks);
      chk($sformatf("seg%0d_hr", s), n_hr, tbl[s].hrs);
      chk($sformatf("seg%0d_min", s), n_min, tbl[s].mins);
      chk($sformatf("seg%0d_tick_end", s), int'(sec_tick), tbl[s].tick_end);
    end

    // reset in SET_MIN with the mode debouncer part-way, button held through release
    btn_mode = 1'b1;
    repeat (4) tick_cycle();
    chk("pre_reset_mode", int'(mode), 2);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_running", int'(running), 1);
    chk("async_rst_tick", int'(sec_tick), 0);
    chk("async_rst_hr", int'(hr_inc), 0);
    chk("async_rst_min", int'(min_inc), 0);
    repeat (2) tick_cycle();
    reset = 1'b0;
    repeat (6) tick_cycle();
    chk("held_press_early", int'(mode), 0);
    tick_cycle();
    chk("held_press_seen", int'(mode), 1);
    btn_mode = 1'b0;
    repeat (10) tick_cycle();

    for (int k = 0; k < 300; k++) begin
      int len;
      btn_mode = ($urandom_range(0, 3) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) tick_cycle();
      if (k % 100 == 60) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_model();
        tick_cycle();
        reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
